// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between CPU writeback (priority) and a buffered debug loader.
// Optional statistics outputs are enabled by defining REGFILE_ARB_STATS_EN.
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cpu_we,
  input  logic [4:0]                 cpu_waddr,
  input  logic [31:0]                cpu_wdata,
  output logic                       cpu_stall,
  input  logic                       dbg_valid,
  output logic                       dbg_ready,
  input  logic [4:0]                 dbg_addr,
  input  logic [31:0]                dbg_data,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
`ifdef REGFILE_ARB_STATS_EN
  output logic [31:0]                stat_dbg_writes,
  output logic [31:0]                stat_stall_cycles,
`endif
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_TC = SW'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, STEAL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [4:0]      mem_addr_q [DEPTH];
  logic [4:0]      mem_addr_d [DEPTH];
  logic [31:0]     mem_data_q [DEPTH];
  logic [31:0]     mem_data_d [DEPTH];

  logic            push, pop, nonempty, steal, we_int;
  logic [4:0]      head_addr;
  logic [31:0]     head_data;

  // Ready is decoded from the registered count so a full FIFO never accepts, even while popping.
  assign dbg_ready  = (count_q < DEPTH_C);
  assign fifo_count = count_q;
  assign cpu_stall  = (state_q == STEAL);
  assign rf_we      = we_int && !reset;

  always_comb begin
    push       = dbg_valid && dbg_ready;
    nonempty   = (count_q != '0);
    steal      = (state_q == STEAL);
    head_addr  = mem_addr_q[rd_ptr_q];
    head_data  = mem_data_q[rd_ptr_q];
    pop        = steal || (!cpu_we && nonempty);
    we_int     = 1'b0;
    rf_waddr   = cpu_waddr;
    rf_wdata   = cpu_wdata;

    if (steal) begin
      we_int   = (head_addr != 5'd0);
      rf_waddr = head_addr;
      rf_wdata = head_data;
    end else if (cpu_we) begin
      we_int   = 1'b1;
    end else if (nonempty) begin
      we_int   = (head_addr != 5'd0);
      rf_waddr = head_addr;
      rf_wdata = head_data;
    end

    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      mem_addr_d[wr_ptr_q] = dbg_addr;
      mem_data_d[wr_ptr_q] = dbg_data;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    count_d  = count_q + CW'(push) - CW'(pop);
    starve_d = (pop || !nonempty) ? '0 : starve_q + 1'b1;

    if (nonempty && !pop && (starve_q == STARVE_TC)) state_d = STEAL;
    else if (count_d != '0)                          state_d = WAIT;
    else                                             state_d = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= '0;
      mem_addr_q <= '{default: '0};
      mem_data_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      starve_q   <= starve_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  logic [31:0] stat_dbg_writes_q, stat_dbg_writes_d;
  logic [31:0] stat_stall_cycles_q, stat_stall_cycles_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stat_dbg_writes_d   = stat_dbg_writes_q;
    stat_stall_cycles_d = stat_stall_cycles_q;
    if (pop && (stat_dbg_writes_q != '1))     stat_dbg_writes_d   = stat_dbg_writes_q + 1'b1;
    if (steal && (stat_stall_cycles_q != '1)) stat_stall_cycles_d = stat_stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_dbg_writes_q   <= '0;
      stat_stall_cycles_q <= '0;
    end else begin
      stat_dbg_writes_q   <= stat_dbg_writes_d;
      stat_stall_cycles_q <= stat_stall_cycles_d;
    end
  end

  assign stat_dbg_writes   = stat_dbg_writes_q;
  assign stat_stall_cycles = stat_stall_cycles_q;
`endif

endmodule
